// File: rtl/camera_pattern_tx.sv
// Synthetic OV7670-style camera source: V_SYNC/HREF framing with RGB565 bytes
// (MSB byte first) expanded from an internal RGB332 test pattern.
module camera_pattern_tx #(
    parameter int H_ACTIVE      = 176,
    parameter int H_BLANK       = 48,
    parameter int V_ACTIVE      = 144,
    parameter int V_SYNC_LINES  = 3,
    parameter int V_BACK_LINES  = 17,
    parameter int V_FRONT_LINES = 10
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [1:0] PATTERN_SEL,
    input  logic [7:0] SOLID_COLOR,
    output logic       V_SYNC,
    output logic       HREF,
    output logic [7:0] DATA,
    output logic       FRAME_DONE
);
    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W    = $clog2(LINE_LEN);
    localparam int LINE_W   = $clog2(V_SYNC_LINES + V_BACK_LINES + V_ACTIVE + V_FRONT_LINES + 1);
    localparam int BAR_PX   = H_ACTIVE / 8;
    localparam int BAR_W    = $clog2(BAR_PX + 1);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_LEN - 1);
    localparam logic [COL_W-1:0]  COL_HREF  = COL_W'(2 * H_ACTIVE);
    localparam logic [BAR_W-1:0]  BAR_LAST  = BAR_W'(BAR_PX - 1);
    localparam logic [LINE_W-1:0] LINE_BIT4 = LINE_W'(16);

    typedef enum logic [2:0] {ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT} state_t;

    state_t            state, state_next;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line, line_last;
    logic              col_end, state_end;
    logic [1:0]        pat_sel;
    logic [7:0]        solid;
    logic [BAR_W-1:0]  bar_cnt;
    logic [2:0]        bar_idx;
    logic [7:0]        x, color, byte0, byte1;
    logic              y_bit4;
    logic [2:0]        r, g;
    logic [1:0]        b;
    logic              vsync_d, href_d, done_d;
    logic [7:0]        data_d;

    always_comb begin
        case (state)
            ST_VSYNC:  line_last = LINE_W'(V_SYNC_LINES - 1);
            ST_VBACK:  line_last = LINE_W'(V_BACK_LINES - 1);
            ST_ACTIVE: line_last = LINE_W'(V_ACTIVE - 1);
            ST_VFRONT: line_last = LINE_W'(V_FRONT_LINES - 1);
            default:   line_last = '0;
        endcase
    end

    assign col_end   = (col == COL_LAST);
    assign state_end = col_end && (line == line_last);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_next;
    end

    // ENABLE only matters in IDLE and on the final VFRONT cycle, so a frame always completes.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (ENABLE)    state_next = ST_VSYNC;
            ST_VSYNC:  if (state_end) state_next = ST_VBACK;
            ST_VBACK:  if (state_end) state_next = ST_ACTIVE;
            ST_ACTIVE: if (state_end) state_next = ST_VFRONT;
            ST_VFRONT: if (state_end) state_next = ENABLE ? ST_VSYNC : ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            col     <= '0;
            line    <= '0;
            pat_sel <= '0;
            solid   <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
        end else begin
            if (state == ST_IDLE || state_next != state) begin
                col  <= '0;
                line <= '0;
            end else begin
                col <= col_end ? '0 : col + 1'b1;
                if (col_end) line <= line + 1'b1;
            end
            if (state_next == ST_VSYNC && state != ST_VSYNC) begin
                pat_sel <= PATTERN_SEL;
                solid   <= SOLID_COLOR;
            end
            // Bar index advances after the odd byte of every BAR_PX-th pixel, saturating at 7.
            if (state != ST_ACTIVE || col_end) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (href_d && col[0]) begin
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= (bar_idx == 3'd7) ? bar_idx : bar_idx + 1'b1;
                end else begin
                    bar_cnt <= bar_cnt + 1'b1;
                end
            end
        end
    end

    assign x      = 8'(col >> 1);
    assign y_bit4 = (line & LINE_BIT4) != '0;

    always_comb begin
        case (pat_sel)
            2'd0:    color = solid;
            2'd1:    color = {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {2{bar_idx[0]}}};
            2'd2:    color = (x[4] ^ y_bit4) ? 8'hE0 : 8'h03;
            default: color = x;
        endcase
    end

    assign {r, g, b} = color;
    assign byte0     = {r, r[2:1], g};
    assign byte1     = {g, b, b, b[1]};

    always_comb begin
        vsync_d = (state == ST_VSYNC);
        href_d  = (state == ST_ACTIVE) && (col < COL_HREF);
        data_d  = href_d ? (col[0] ? byte1 : byte0) : 8'h00;
        done_d  = (state == ST_VFRONT) && state_end;
    end

    // NOTE: registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            V_SYNC     <= 1'b0;
            HREF       <= 1'b0;
            DATA       <= 8'h00;
            FRAME_DONE <= 1'b0;
        end else begin
            V_SYNC     <= vsync_d;
            HREF       <= href_d;
            DATA       <= data_d;
            FRAME_DONE <= done_d;
        end
    end
endmodule

// File: tb/tb_camera_pattern_tx.sv
// Randomised bench for camera_pattern_tx: a frame-arithmetic reference model
// predicts every output cycle, plus framing measurements and pixel spot checks.
module tb_camera_pattern_tx;
    localparam int H_ACTIVE      = 176;
    localparam int H_BLANK       = 8;
    localparam int V_ACTIVE      = 17;
    localparam int V_SYNC_LINES  = 2;
    localparam int V_BACK_LINES  = 1;
    localparam int V_FRONT_LINES = 1;
    localparam int L = 2 * H_ACTIVE + H_BLANK;
    localparam int F = (V_SYNC_LINES + V_BACK_LINES + V_ACTIVE + V_FRONT_LINES) * L;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       ENABLE = 1'b0;
    logic [1:0] PATTERN_SEL = 2'd0;
    logic [7:0] SOLID_COLOR = 8'h00;
    logic       V_SYNC, HREF, FRAME_DONE;
    logic [7:0] DATA;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLOCK = ~CLOCK;

    camera_pattern_tx #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
        .V_SYNC_LINES(V_SYNC_LINES), .V_BACK_LINES(V_BACK_LINES), .V_FRONT_LINES(V_FRONT_LINES)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .PATTERN_SEL(PATTERN_SEL),
        .SOLID_COLOR(SOLID_COLOR), .V_SYNC(V_SYNC), .HREF(HREF), .DATA(DATA), .FRAME_DONE(FRAME_DONE)
    );

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
            if (n_fail >= 40) finish_run();
        end
    endtask

    function automatic logic [7:0] pattern_color(int sel, int solid_c, int x, int y);
        int k;
        case (sel)
            0: return 8'(solid_c);
            1: begin
                k = x / (H_ACTIVE / 8);
                if (k > 7) k = 7;
                return 8'((k / 4) * 'hE0 + ((k / 2) % 2) * 'h1C + (k % 2) * 'h03);
            end
            2: return (((x / 16) % 2) != ((y / 16) % 2)) ? 8'hE0 : 8'h03;
            default: return 8'(x % 256);
        endcase
    endfunction

    function automatic logic [15:0] to_rgb565(logic [7:0] c);
        int rr, gg, bb;
        rr = int'(c) / 32;
        gg = (int'(c) / 4) % 8;
        bb = int'(c) % 4;
        return 16'((rr * 4 + rr / 2) * 2048 + (gg * 9) * 32 + (bb * 10 + bb / 2));
    endfunction

    // {V_SYNC, HREF, DATA, FRAME_DONE} at cycle t of a frame (t = 0 is the V_SYNC rise).
    function automatic logic [10:0] frame_out(int t, int sel, int solid_c);
        int row, col, y;
        logic [15:0] px;
        logic [7:0]  d;
        logic        vs, hr;
        row = t / L;
        col = t % L;
        y   = row - V_SYNC_LINES - V_BACK_LINES;
        vs  = (row < V_SYNC_LINES);
        hr  = (y >= 0) && (y < V_ACTIVE) && (col < 2 * H_ACTIVE);
        d   = 8'h00;
        if (hr) begin
            px = to_rgb565(pattern_color(sel, solid_c, col / 2, y));
            d  = (col % 2 == 0) ? px[15:8] : px[7:0];
        end
        return {vs, hr, d, (t == F - 1)};
    endfunction

    // Reference model: frame start edges and the inputs latched at each start.
    int cyc = 0;
    bit cur_valid = 0, prev_valid = 0;
    int cur_vs, prev_vs, cur_sel, prev_sel, cur_solid, prev_solid;
    int frames_started = 0;

    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cur_valid  = 0;
            prev_valid = 0;
        end else begin
            cyc++;
            if (!(cur_valid && cyc < cur_vs + F - 1) && ENABLE) begin
                prev_valid = cur_valid;
                prev_vs    = cur_vs;
                prev_sel   = cur_sel;
                prev_solid = cur_solid;
                cur_valid  = 1;
                cur_vs     = cyc + 1;
                cur_sel    = int'(PATTERN_SEL);
                cur_solid  = int'(SOLID_COLOR);
                frames_started++;
            end
        end
    end

    function automatic logic [10:0] expected_now();
        if (RESET) return '0;
        if (cur_valid && cyc >= cur_vs && cyc < cur_vs + F)
            return frame_out(cyc - cur_vs, cur_sel, cur_solid);
        if (prev_valid && cyc >= prev_vs && cyc < prev_vs + F)
            return frame_out(cyc - prev_vs, prev_sel, prev_solid);
        return '0;
    endfunction

    task automatic spot(int sel, int solid_c, int x, int y, logic [15:0] pair);
        if (sel == 0 && x == 5 && y == 3) begin
            case (solid_c)
                'hE0:    check("solid_e0", 32'(pair), 'hF800);
                'h1C:    check("solid_1c", 32'(pair), 'h07E0);
                'h03:    check("solid_03", 32'(pair), 'h001F);
                'hFF:    check("solid_ff", 32'(pair), 'hFFFF);
                default: ;
            endcase
        end
        if (sel == 1 && y == 0) begin
            if (x == 0)   check("bar0",       32'(pair), 'h0000);
            if (x == 21)  check("bar0_last",  32'(pair), 'h0000);
            if (x == 22)  check("bar1_first", 32'(pair), 'h001F);
            if (x == 88)  check("bar4",       32'(pair), 'hF800);
            if (x == 175) check("bar7",       32'(pair), 'hFFFF);
        end
        if (sel == 2) begin
            if (x == 0  && y == 0)  check("chk_0_0",   32'(pair), 'h001F);
            if (x == 15 && y == 0)  check("chk_15_0",  32'(pair), 'h001F);
            if (x == 16 && y == 0)  check("chk_16_0",  32'(pair), 'hF800);
            if (x == 16 && y == 16) check("chk_16_16", 32'(pair), 'h001F);
        end
    endtask

    // Monitor: per-cycle model comparison, spot pixels and framing measurements.
    logic [7:0] last_data = 8'h00;
    int  vs_len = 0, href_len = 0, gap_len = 0, since_vs = 0, windows = 0, done_count = 0;
    bit  seen_vs = 0, first_href = 0, prev_vs_s = 0, prev_href_s = 0;

    always @(negedge CLOCK) begin
        int t, row, col;
        check("outputs", 32'({V_SYNC, HREF, DATA, FRAME_DONE}), 32'(expected_now()));
        if (RESET) begin
            seen_vs     = 0;
            prev_vs_s   = 0;
            prev_href_s = 0;
        end else begin
            if (cur_valid && cyc >= cur_vs && cyc < cur_vs + F) begin
                t   = cyc - cur_vs;
                row = t / L - V_SYNC_LINES - V_BACK_LINES;
                col = t % L;
                if (row >= 0 && row < V_ACTIVE && col < 2 * H_ACTIVE && col % 2 == 1)
                    spot(cur_sel, cur_solid, col / 2, row, {last_data, DATA});
            end
            if (V_SYNC && !prev_vs_s) begin
                seen_vs = 1; since_vs = 0; windows = 0; first_href = 1; vs_len = 1;
            end else begin
                since_vs++;
                if (V_SYNC) vs_len++;
            end
            if (!V_SYNC && prev_vs_s) check("vsync_len", 32'(vs_len), 32'(V_SYNC_LINES * L));
            if (HREF && !prev_href_s) begin
                if (seen_vs && first_href) check("href_first", 32'(since_vs), 32'((V_SYNC_LINES + V_BACK_LINES) * L));
                else if (seen_vs)          check("href_gap", 32'(gap_len), 32'(H_BLANK));
                first_href = 0;
                href_len   = 1;
            end else if (HREF) href_len++;
            if (!HREF && prev_href_s) begin
                check("href_len", 32'(href_len), 32'(2 * H_ACTIVE));
                windows++;
                gap_len = 1;
            end else if (!HREF) gap_len++;
            if (FRAME_DONE && seen_vs) begin
                check("frame_len", 32'(since_vs), 32'(F - 1));
                check("href_windows", 32'(windows), 32'(V_ACTIVE));
            end
            if (FRAME_DONE) done_count++;
            prev_vs_s   = V_SYNC;
            prev_href_s = HREF;
        end
        last_data = DATA;
    end

    task automatic wait_frames(int n);
        for (int k = 0; k < 3 * F && frames_started < n; k++) @(negedge CLOCK);
        if (frames_started < n) begin
            check("frame_start_timeout", 32'(frames_started), 32'(n));
            finish_run();
        end
    endtask

    task automatic wait_done(int n);
        for (int k = 0; k < 3 * F && done_count < n; k++) @(negedge CLOCK);
        check("frame_done_count", 32'(done_count), 32'(n));
    endtask

    initial begin
        int sel_plan [7] = '{0, 0, 0, 0, 1, 2, 3};
        int solid_plan [7];
        int a, b, target, n;
        solid_plan = '{'hE0, 'h1C, 'h03, 'hFF, 0, 0, 0};
        for (int i = 4; i < 7; i++) solid_plan[i] = int'($urandom_range(0, 255));

        #1 RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        check("rst_vsync", 32'(V_SYNC), 0);
        check("rst_href",  32'(HREF), 0);
        check("rst_data",  32'(DATA), 0);
        check("rst_done",  32'(FRAME_DONE), 0);
        RESET = 1'b0;
        repeat (5) @(negedge CLOCK);

        PATTERN_SEL = 2'(sel_plan[0]);
        SOLID_COLOR = 8'(solid_plan[0]);
        ENABLE      = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_frames(i + 1);
            a = int'($urandom_range(10, F / 2));
            b = int'($urandom_range(F / 2 + 1, F - 20));
            repeat (a) @(negedge CLOCK);
            PATTERN_SEL = 2'($urandom);
            SOLID_COLOR = 8'($urandom);
            if (i < 6) ENABLE = 1'b0;
            repeat (b - a) @(negedge CLOCK);
            if (i < 6) begin
                ENABLE      = 1'b1;
                PATTERN_SEL = 2'(sel_plan[i + 1]);
                SOLID_COLOR = 8'(solid_plan[i + 1]);
            end else begin
                ENABLE = 1'b0;
            end
        end
        wait_done(7);
        repeat (40) @(negedge CLOCK);
        check("idle_vsync", 32'(V_SYNC), 0);

        // Reset in the middle of an active line, then a full frame again.
        PATTERN_SEL = 2'd2;
        SOLID_COLOR = 8'($urandom);
        ENABLE      = 1'b1;
        wait_frames(8);
        ENABLE = 1'b0;
        target = (V_SYNC_LINES + V_BACK_LINES + 4) * L + int'($urandom_range(2, 2 * H_ACTIVE - 10));
        n = 0;
        do begin
            @(posedge CLOCK);
            #1;
            n++;
        end while (cyc < cur_vs + target && n < 2 * F);
        check("href_before_reset", 32'(HREF), 1);
        #1 RESET = 1'b1;
        #1;
        check("async_rst_href",  32'(HREF), 0);
        check("async_rst_vsync", 32'(V_SYNC), 0);
        check("async_rst_data",  32'(DATA), 0);
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        repeat (10) @(negedge CLOCK);
        PATTERN_SEL = 2'd3;
        ENABLE      = 1'b1;
        wait_frames(9);
        repeat (F / 2) @(negedge CLOCK);
        ENABLE = 1'b0;
        wait_done(8);
        repeat (20) @(negedge CLOCK);
        check("final_idle_href", 32'(HREF), 0);
        finish_run();
    end
endmodule
